// File: rtl/ppu_compositor.sv
// Pixel compositor: background/sprite priority resolve, mirrored palette RAM lookup, collision flag.
// Optional build macro PPU_COMP_GREYSCALE_EN adds greyscale_in, which masks bits [3:0] of the lookup.
module ppu_compositor #(
  parameter int unsigned SPR_CH      = 1,
  parameter int unsigned COLOR_W     = 6,
  parameter int unsigned PRAM_MIRROR = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  pix_pulse_in,
  input  logic                  frame_start_in,
  input  logic [3:0]            bg_idx_in,
  input  logic [4*SPR_CH-1:0]   spr_idx_in,
  input  logic [SPR_CH-1:0]     spr_pri_in,
  input  logic [SPR_CH-1:0]     spr_primary_in,
  input  logic [4:0]            pram_a_in,
  input  logic [COLOR_W-1:0]    pram_d_in,
  input  logic                  pram_wr_in,
  output logic [COLOR_W-1:0]    pram_d_out,
  output logic [COLOR_W-1:0]    sys_idx_out,
  output logic                  sys_idx_vld_out,
  output logic                  pri_col_out
`ifdef PPU_COMP_GREYSCALE_EN
  ,
  input  logic                  greyscale_in
`endif
);

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PAL_DEPTH = 32;
  localparam logic [COLOR_W-1:0] PAL_RST = COLOR_W'(32'h0F);

  // Entries 0x10/0x14/0x18/0x1C fold onto the backdrop entries when mirroring is on.
  function automatic logic [ADDR_W-1:0] mirror(input logic [ADDR_W-1:0] a);
    if (PRAM_MIRROR != 0 && a[1:0] == 2'b00) return {1'b0, a[3:0]};
    return a;
  endfunction

  logic [COLOR_W-1:0] pal_q [PAL_DEPTH];
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
  logic               s1_vld_q;
  logic [COLOR_W-1:0] sys_idx_q, sys_idx_d;
  logic               sys_vld_q;
  logic               pri_col_q, pri_col_d;

  logic [SPR_CH-1:0]  spr_opaque;
  logic               bg_opaque;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               win_pri;
  logic [COLOR_W-1:0] lookup;

  // Priority resolve: lowest-index opaque channel wins; its priority bit alone decides.
  always_comb begin
    bg_opaque = |bg_idx_in[1:0];
    win_found = 1'b0;
    win_idx   = '0;
    win_pri   = 1'b0;
    spr_opaque = '0;
    for (int c = 0; c < int'(SPR_CH); c++) begin
      spr_opaque[c] = |spr_idx_in[4*c +: 2];
      if (!win_found && spr_opaque[c]) begin
        win_found = 1'b1;
        win_idx   = spr_idx_in[4*c +: 4];
        win_pri   = spr_pri_in[c];
      end
    end
    if (win_found && (!win_pri || !bg_opaque)) s1_addr_d = {1'b1, win_idx};
    else if (bg_opaque)                       s1_addr_d = {1'b0, bg_idx_in};
    else                                      s1_addr_d = '0;
  end

  // S2 lookup reads the registered array, so a same-cycle write returns the old value.
  always_comb begin
    lookup = pal_q[mirror(s1_addr_q)];
`ifdef PPU_COMP_GREYSCALE_EN
    if (greyscale_in) lookup = lookup & ~COLOR_W'(4'hF);
`endif
    sys_idx_d = s1_vld_q ? lookup : sys_idx_q;
  end

  // Frame start has precedence over a coincident collision.
  always_comb begin
    pri_col_d = pri_col_q;
    if (frame_start_in)
      pri_col_d = 1'b0;
    else if (pix_pulse_in && bg_opaque && |(spr_primary_in & spr_opaque))
      pri_col_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_addr_q <= '0;
      s1_vld_q  <= 1'b0;
      sys_idx_q <= '0;
      sys_vld_q <= 1'b0;
      pri_col_q <= 1'b0;
    end else begin
      s1_addr_q <= s1_addr_d;
      s1_vld_q  <= pix_pulse_in;
      sys_idx_q <= sys_idx_d;
      sys_vld_q <= s1_vld_q;
      pri_col_q <= pri_col_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(PAL_DEPTH); i++) pal_q[i] <= PAL_RST;
    end else if (pram_wr_in) begin
      pal_q[mirror(pram_a_in)] <= pram_d_in;
    end
  end

  assign pram_d_out      = pal_q[mirror(pram_a_in)];
  assign sys_idx_out     = sys_idx_q;
  assign sys_idx_vld_out = sys_vld_q;
  assign pri_col_out     = pri_col_q;

endmodule

// File: doc/ppu_compositor.md
# ppu_compositor

Parametrised pixel compositor for the PPU: merges the background index with up to SPR_CH sprite channels, resolves priority, and translates the winning 5-bit palette address through an internal mirrored palette RAM into a system palette index for ppu_vga. It also maintains the primary-object collision flag for the register interface. It is the multi-channel, pipelined successor to the compositing logic in the PPU top level, and replaces that logic.

## Interface
Parameters:
- SPR_CH, 1: number of sprite channels, legal 1..8; channel 0 has highest priority.
- COLOR_W, 6: width of a palette RAM entry and of the output index.
- PRAM_MIRROR, 1: 1 = addresses 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C; 0 = all 32 entries distinct.

Ports:
- clk_in  in  1  100 MHz system clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- pix_pulse_in  in  1  one-cycle strobe; the pixel inputs are valid this cycle.
- frame_start_in  in  1  one-cycle strobe at the first line of a frame; clears the collision flag.
- bg_idx_in  in  4  background {palette, pixel}; the pixel is transparent when bits [1:0] are 0.
- spr_idx_in  in  4*SPR_CH  per-channel sprite {palette, pixel}; channel c occupies bits [4c+3:4c].
- spr_pri_in  in  SPR_CH  per-channel priority; 1 = behind background.
- spr_primary_in  in  SPR_CH  per-channel flag marking the primary object (sprite 0).
- pram_a_in  in  5  CPU palette address.
- pram_d_in  in  COLOR_W  CPU palette write data.
- pram_wr_in  in  1  CPU palette write strobe.
- pram_d_out  out  COLOR_W  CPU palette read data; combinational from pram_a_in after mirroring.
- sys_idx_out  out  COLOR_W  system palette index sent to ppu_vga.
- sys_idx_vld_out  out  1  one-cycle strobe; sys_idx_out was updated this cycle.
- pri_col_out  out  1  primary-object collision flag.
- greyscale_in  in  1  present only when PPU_COMP_GREYSCALE_EN is defined.

## Operation
- Mirroring function M(a): with PRAM_MIRROR=1, M(a) = a & 0x0F when a[1:0]==0, otherwise M(a) = a. With PRAM_MIRROR=0, M(a) = a. Every palette read and write goes through M.
- Sprite select: the winning channel is the lowest-index channel whose pixel is opaque. Its priority bit alone decides the result. A higher-index, front-priority sprite cannot show through a lower-index, behind-priority sprite.
- Final address:
  - {1, spr_idx[w]} when a winner w exists and either spr_pri_in[w]==0 or the background is transparent;
  - otherwise {0, bg_idx} when the background is opaque;
  - otherwise 0x00.
- Collision: set on a pix_pulse_in cycle when some channel has its spr_primary bit set, that channel's pixel is opaque, and the background is opaque. The channel does not have to be the winner. The flag is sticky until frame_start_in.
- Palette write: on pram_wr_in, entry M(pram_a_in) <= pram_d_in. The write takes effect the following cycle.

## Timing
- Pipeline advances every clock:
  - S1 registers the final address and a valid bit (valid = pix_pulse_in).
  - S2 registers palette[M(S1 address)] into sys_idx_out and the valid bit into sys_idx_vld_out.
- Latency: 2 clocks from pix_pulse_in to sys_idx_vld_out. Back-to-back pulses give one result per clock.
- sys_idx_out holds its value on cycles where the S1 valid bit is 0.
- Write/lookup conflict: when a write and an S2 lookup hit the same entry in the same cycle, the lookup returns the old value.
- Collision flag:
  - updates 1 clock after the qualifying pulse;
  - frame_start_in clears it 1 clock later;
  - frame_start_in wins when it coincides with a set condition.
- Reset values:
  - sys_idx_out = 0, sys_idx_vld_out = 0, pri_col_out = 0, S1 registers = 0;
  - every palette entry = 0x0F masked to COLOR_W.
- Reset asserted mid-pipeline discards in-flight pixels. No strobe is emitted after release until a new pix_pulse_in arrives.

## Configuration
- PPU_COMP_GREYSCALE_EN defined: the greyscale_in port exists. When greyscale_in is 1, S2 clears bits [3:0] of the looked-up value before registering it. The value is sampled in the S2 cycle.
- PPU_COMP_GREYSCALE_EN undefined: the port is absent and no masking is applied.

## Test plan
- Reset, then pix_pulse_in with bg=0x5 and all sprites transparent: sys_idx_vld_out pulses exactly 2 clocks later with sys_idx_out=0x0F; pri_col_out=0.
- SPR_CH=2, ch0 idx 0x6 with pri=1, ch1 idx 0x7 with pri=0, bg 0x1 opaque: address resolves to 0x01 (background) and sys_idx_out equals palette[0x01].
- PRAM_MIRROR=1: write 0x2A to address 0x10, then read address 0x00 → pram_d_out=0x2A. A pixel with bg transparent and no sprites outputs 0x2A.
- spr_primary_in[1]=1 with ch1 opaque and bg opaque: pri_col_out=1 the next clock and stays 1. frame_start_in asserted in the same cycle as a new set condition → pri_col_out=0.
- Write 0x11 to entry 0x05 in the same cycle that S2 reads 0x05: output is the old value; the next lookup of 0x05 returns 0x11.
- With PPU_COMP_GREYSCALE_EN defined and greyscale_in=1 on a lookup of an entry holding 0x2C: sys_idx_out=0x20.
